// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: fetch / decode / execute T-step sequencer.
// Optional mul/div execution is enabled by defining MUL_DIV_EN.
module control_sequencer #(
  parameter int unsigned OPW = 5
) (
  input  logic           clock,
  input  logic           clear,
  input  logic [31:0]    IR,
  input  logic           mem_done,
  output logic           PCout,
  output logic           Zloout,
  output logic           Zhiout,
  output logic           MDRout,
  output logic           Rout,
  output logic           BAout,
  output logic           Cout,
  output logic           MAR_in,
  output logic           Z_in,
  output logic           MDR_in,
  output logic           IR_in,
  output logic           Y_in,
  output logic           HI_in,
  output logic           LO_in,
  output logic           Rin,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           IncPC,
  output logic           Read,
  output logic           Write,
  output logic [OPW-1:0] alu_op,
  output logic           run,
  output logic           illegal,
  output logic [3:0]     step
);

  typedef enum logic [3:0] {
    StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
  } state_e;

  typedef enum logic [3:0] {
    ClsAlu, ClsImm, ClsUn, ClsLdi, ClsLd, ClsSt, ClsNop, ClsHalt, ClsMulDiv, ClsIll
  } cls_e;

  localparam logic [OPW-1:0] OpLd   = OPW'(0);
  localparam logic [OPW-1:0] OpLdi  = OPW'(1);
  localparam logic [OPW-1:0] OpSt   = OPW'(2);
  localparam logic [OPW-1:0] OpAdd  = OPW'(3);
  localparam logic [OPW-1:0] OpShl  = OPW'(11);
  localparam logic [OPW-1:0] OpAddi = OPW'(12);
  localparam logic [OPW-1:0] OpOri  = OPW'(14);
  localparam logic [OPW-1:0] OpDiv  = OPW'(15);
  localparam logic [OPW-1:0] OpMul  = OPW'(16);
  localparam logic [OPW-1:0] OpNeg  = OPW'(17);
  localparam logic [OPW-1:0] OpNot  = OPW'(18);
  localparam logic [OPW-1:0] OpNop  = OPW'(26);
  localparam logic [OPW-1:0] OpHalt = OPW'(27);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  cls_e   cls;

  logic [OPW-1:0] op;
  logic           unused_ir;
  assign op        = IR[31 -: OPW];
  assign unused_ir = ^IR[31-OPW:0];

  always_comb begin
    cls = ClsIll;
    if (op == OpLd)                        cls = ClsLd;
    else if (op == OpLdi)                  cls = ClsLdi;
    else if (op == OpSt)                   cls = ClsSt;
    else if (op >= OpAdd && op <= OpShl)   cls = ClsAlu;
    else if (op >= OpAddi && op <= OpOri)  cls = ClsImm;
    else if (op == OpNeg || op == OpNot)   cls = ClsUn;
    else if (op == OpNop)                  cls = ClsNop;
    else if (op == OpHalt)                 cls = ClsHalt;
`ifdef MUL_DIV_EN
    else if (op == OpMul || op == OpDiv)   cls = ClsMulDiv;
`endif
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= StRst;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      StRst: state_d = StT0;
      StT0:  state_d = StT1;
      StT1:  if (mem_done) state_d = StT2;
      StT2:  state_d = StT3;
      StT3: begin
        case (cls)
          ClsNop:  state_d = StT0;
          ClsHalt: state_d = StHalt;
          ClsIll: begin
            state_d   = StHalt;
            illegal_d = 1'b1;
          end
          default: state_d = StT4;
        endcase
      end
      StT4:  state_d = (cls == ClsUn) ? StT0 : StT5;
      StT5:  state_d = (cls == ClsLd || cls == ClsSt || cls == ClsMulDiv) ? StT6 : StT0;
      StT6: begin
        if (cls == ClsLd)      state_d = mem_done ? StT7 : StT6;
        else if (cls == ClsSt) state_d = StT7;
        else                   state_d = StT0;
      end
      // Only st waits in T7; ld finishes its register write in one cycle.
      StT7:  if (cls != ClsSt || mem_done) state_d = StT0;
      StHalt: state_d = StHalt;
      default: state_d = StRst;
    endcase
  end

  always_comb begin
    {PCout, Zloout, Zhiout, MDRout, Rout, BAout, Cout} = '0;
    {MAR_in, Z_in, MDR_in, IR_in, Y_in, HI_in, LO_in, Rin} = '0;
    {Gra, Grb, Grc, IncPC, Read, Write} = '0;
    alu_op  = '0;
    run     = 1'b1;
    illegal = illegal_q;
    step    = 4'd0;
    case (state_q)
      StT0: {PCout, MAR_in, IncPC} = 3'b111;
      StT1: begin
        step          = 4'd1;
        {Read, MDR_in} = 2'b11;
      end
      StT2: begin
        step            = 4'd2;
        {MDRout, IR_in} = 2'b11;
      end
      StT3: begin
        step = 4'd3;
        case (cls)
          ClsAlu, ClsImm:        {Grb, Rout, Y_in} = 3'b111;
          ClsUn: begin
            {Grb, Rout, Z_in} = 3'b111;
            alu_op            = op;
          end
          ClsLdi, ClsLd, ClsSt:  {Grb, BAout, Y_in} = 3'b111;
`ifdef MUL_DIV_EN
          ClsMulDiv:             {Gra, Rout, Y_in} = 3'b111;
`endif
          default: ;
        endcase
      end
      StT4: begin
        step = 4'd4;
        case (cls)
          ClsAlu: begin
            {Grc, Rout, Z_in} = 3'b111;
            alu_op            = op;
          end
          ClsImm: begin
            {Cout, Z_in} = 2'b11;
            alu_op       = op;
          end
          ClsUn:                 {Zloout, Gra, Rin} = 3'b111;
          // Address formation for ldi/ld/st is always an add.
          ClsLdi, ClsLd, ClsSt: begin
            {Cout, Z_in} = 2'b11;
            alu_op       = OpAdd;
          end
`ifdef MUL_DIV_EN
          ClsMulDiv: begin
            {Grb, Rout, Z_in} = 3'b111;
            alu_op            = op;
          end
`endif
          default: ;
        endcase
      end
      StT5: begin
        step = 4'd5;
        case (cls)
          ClsAlu, ClsImm, ClsLdi: {Zloout, Gra, Rin} = 3'b111;
          ClsLd, ClsSt:           {Zloout, MAR_in} = 2'b11;
`ifdef MUL_DIV_EN
          ClsMulDiv:              {Zloout, LO_in} = 2'b11;
`endif
          default: ;
        endcase
      end
      StT6: begin
        step = 4'd6;
        case (cls)
          ClsLd:     {Read, MDR_in} = 2'b11;
          ClsSt:     {Gra, Rout, MDR_in} = 3'b111;
`ifdef MUL_DIV_EN
          ClsMulDiv: {Zhiout, HI_in} = 2'b11;
`endif
          default: ;
        endcase
      end
      StT7: begin
        step = 4'd7;
        case (cls)
          ClsLd:   {MDRout, Gra, Rin} = 3'b111;
          ClsSt:   {MDRout, Write} = 2'b11;
          default: ;
        endcase
      end
      // Halt is only reachable from T3, so the step reads back as 3.
      StHalt: begin
        run  = 1'b0;
        step = 4'd3;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the driver queues the expected output
// word for each cycle, a monitor pops and compares it on the falling edge.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        mem_done = 1'b0;
  logic [31:0] IR = '0;

  logic PCout, Zloout, Zhiout, MDRout, Rout, BAout, Cout;
  logic MAR_in, Z_in, MDR_in, IR_in, Y_in, HI_in, LO_in, Rin;
  logic Gra, Grb, Grc, IncPC, Read, Write, run, illegal;
  logic [4:0]  alu_op;
  logic [3:0]  step;
  logic [31:0] obs;

  control_sequencer #(.OPW(5)) dut (
    .clock(clock), .clear(clear), .IR(IR), .mem_done(mem_done),
    .PCout(PCout), .Zloout(Zloout), .Zhiout(Zhiout), .MDRout(MDRout), .Rout(Rout),
    .BAout(BAout), .Cout(Cout), .MAR_in(MAR_in), .Z_in(Z_in), .MDR_in(MDR_in),
    .IR_in(IR_in), .Y_in(Y_in), .HI_in(HI_in), .LO_in(LO_in), .Rin(Rin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write),
    .alu_op(alu_op), .run(run), .illegal(illegal), .step(step)
  );

  always #5 clock = ~clock;

  assign obs = {PCout, Zloout, Zhiout, MDRout, Rout, BAout, Cout, MAR_in, Z_in, MDR_in,
                IR_in, Y_in, HI_in, LO_in, Rin, Gra, Grb, Grc, IncPC, Read, Write,
                alu_op, run, illegal, step};

  localparam logic [20:0] NONE = '0;
  localparam logic [20:0] PCO  = 21'b1 << 20;
  localparam logic [20:0] ZLO  = 21'b1 << 19;
  localparam logic [20:0] ZHI  = 21'b1 << 18;
  localparam logic [20:0] MDRO = 21'b1 << 17;
  localparam logic [20:0] RO   = 21'b1 << 16;
  localparam logic [20:0] BAO  = 21'b1 << 15;
  localparam logic [20:0] CO   = 21'b1 << 14;
  localparam logic [20:0] MARI = 21'b1 << 13;
  localparam logic [20:0] ZI   = 21'b1 << 12;
  localparam logic [20:0] MDRI = 21'b1 << 11;
  localparam logic [20:0] IRI  = 21'b1 << 10;
  localparam logic [20:0] YI   = 21'b1 << 9;
  localparam logic [20:0] HII  = 21'b1 << 8;
  localparam logic [20:0] LOI  = 21'b1 << 7;
  localparam logic [20:0] RIN  = 21'b1 << 6;
  localparam logic [20:0] GRA  = 21'b1 << 5;
  localparam logic [20:0] GRB  = 21'b1 << 4;
  localparam logic [20:0] GRC  = 21'b1 << 3;
  localparam logic [20:0] INC  = 21'b1 << 2;
  localparam logic [20:0] RD   = 21'b1 << 1;
  localparam logic [20:0] WR   = 21'b1;

  localparam logic [31:0] W_RST  = {21'b0, 5'b0, 1'b1, 1'b0, 4'd0};
  localparam logic [31:0] W_HALT = {21'b0, 5'b0, 1'b0, 1'b0, 4'd3};
  localparam logic [31:0] W_ILL  = {21'b0, 5'b0, 1'b0, 1'b1, 4'd3};

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  function automatic logic [31:0] ew(input logic [20:0] s, input logic [4:0] a,
                                     input logic [3:0] st);
    return {s, a, 1'b1, 1'b0, st};
  endfunction

  // Drive inputs for the coming edge and queue what the current state must show.
  task automatic cyc(input logic c, input logic md, input logic [31:0] e, input string nm);
    @(posedge clock);
    #1;
    clear    = c;
    mem_done = md;
    sb.push_back('{exp: e, name: nm});
  endtask

  task automatic fetch(input logic [31:0] ir, input int w);
    cyc(1'b0, 1'b1, ew(PCO | MARI | INC, 5'd0, 4'd0), "t0");
    IR = ir;
    repeat (w) cyc(1'b0, 1'b0, ew(RD | MDRI, 5'd0, 4'd1), "t1_wait");
    cyc(1'b0, 1'b1, ew(RD | MDRI, 5'd0, 4'd1), "t1");
    cyc(1'b0, 1'b0, ew(MDRO | IRI, 5'd0, 4'd2), "t2");
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        n_checks++;
        if (obs === x.exp) n_pass++;
        else $display("FAIL %s: got %h required %h at %0t", x.name, obs, x.exp, $time);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "bench did not finish");
  end

  initial begin : stim
    // Reset: two edges with clear high, then release.
    cyc(1'b1, 1'b1, W_RST, "rst0");
    cyc(1'b0, 1'b1, W_RST, "rst1");

    // add r?, opcode 00011
    fetch(32'h18C1_0000, 0);
    cyc(1'b0, 1'b1, ew(GRB | RO | YI, 5'd0, 4'd3), "add_t3");
    cyc(1'b0, 1'b1, ew(GRC | RO | ZI, 5'd3, 4'd4), "add_t4");
    cyc(1'b0, 1'b1, ew(ZLO | GRA | RIN, 5'd0, 4'd5), "add_t5");

    // sub with two fetch wait cycles
    fetch(32'h2000_0000, 2);
    cyc(1'b0, 1'b0, ew(GRB | RO | YI, 5'd0, 4'd3), "sub_t3");
    cyc(1'b0, 1'b0, ew(GRC | RO | ZI, 5'd4, 4'd4), "sub_t4");
    cyc(1'b0, 1'b0, ew(ZLO | GRA | RIN, 5'd0, 4'd5), "sub_t5");

    // addi
    fetch(32'h6000_0000, 0);
    cyc(1'b0, 1'b0, ew(GRB | RO | YI, 5'd0, 4'd3), "addi_t3");
    cyc(1'b0, 1'b0, ew(CO | ZI, 5'd12, 4'd4), "addi_t4");
    cyc(1'b0, 1'b0, ew(ZLO | GRA | RIN, 5'd0, 4'd5), "addi_t5");

    // neg
    fetch(32'h8800_0000, 0);
    cyc(1'b0, 1'b0, ew(GRB | RO | ZI, 5'd17, 4'd3), "neg_t3");
    cyc(1'b0, 1'b0, ew(ZLO | GRA | RIN, 5'd0, 4'd4), "neg_t4");

    // ldi
    fetch(32'h0800_0000, 0);
    cyc(1'b0, 1'b0, ew(GRB | BAO | YI, 5'd0, 4'd3), "ldi_t3");
    cyc(1'b0, 1'b0, ew(CO | ZI, 5'd3, 4'd4), "ldi_t4");
    cyc(1'b0, 1'b0, ew(ZLO | GRA | RIN, 5'd0, 4'd5), "ldi_t5");

    // ld with three wait cycles in T6
    fetch(32'h0000_0000, 0);
    cyc(1'b0, 1'b1, ew(GRB | BAO | YI, 5'd0, 4'd3), "ld_t3");
    cyc(1'b0, 1'b1, ew(CO | ZI, 5'd3, 4'd4), "ld_t4");
    cyc(1'b0, 1'b0, ew(ZLO | MARI, 5'd0, 4'd5), "ld_t5");
    repeat (3) cyc(1'b0, 1'b0, ew(RD | MDRI, 5'd0, 4'd6), "ld_t6_wait");
    cyc(1'b0, 1'b1, ew(RD | MDRI, 5'd0, 4'd6), "ld_t6");
    cyc(1'b0, 1'b0, ew(MDRO | GRA | RIN, 5'd0, 4'd7), "ld_t7");

    // nop
    fetch(32'hD000_0000, 0);
    cyc(1'b0, 1'b0, ew(NONE, 5'd0, 4'd3), "nop_t3");

    // st with one write wait cycle
    fetch(32'h1000_0000, 0);
    cyc(1'b0, 1'b0, ew(GRB | BAO | YI, 5'd0, 4'd3), "st_t3");
    cyc(1'b0, 1'b0, ew(CO | ZI, 5'd3, 4'd4), "st_t4");
    cyc(1'b0, 1'b0, ew(ZLO | MARI, 5'd0, 4'd5), "st_t5");
    cyc(1'b0, 1'b0, ew(GRA | RO | MDRI, 5'd0, 4'd6), "st_t6");
    cyc(1'b0, 1'b0, ew(MDRO | WR, 5'd0, 4'd7), "st_t7_wait");
    cyc(1'b0, 1'b1, ew(MDRO | WR, 5'd0, 4'd7), "st_t7");

    // mul
    fetch(32'h8000_0000, 0);
`ifdef MUL_DIV_EN
    cyc(1'b0, 1'b0, ew(GRA | RO | YI, 5'd0, 4'd3), "mul_t3");
    cyc(1'b0, 1'b0, ew(GRB | RO | ZI, 5'd16, 4'd4), "mul_t4");
    cyc(1'b0, 1'b0, ew(ZLO | LOI, 5'd0, 4'd5), "mul_t5");
    cyc(1'b0, 1'b0, ew(ZHI | HII, 5'd0, 4'd6), "mul_t6");
`else
    cyc(1'b0, 1'b0, ew(NONE, 5'd0, 4'd3), "mul_t3");
    cyc(1'b0, 1'b0, W_ILL, "mul_illegal");
    cyc(1'b1, 1'b0, W_ILL, "mul_illegal_clr");
    cyc(1'b0, 1'b0, W_RST, "mul_rst");
`endif

    // halt: frozen for 20 cycles, mem_done toggling is ignored
    fetch(32'hD800_0000, 0);
    cyc(1'b0, 1'b1, ew(NONE, 5'd0, 4'd3), "halt_t3");
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'(i % 2), W_HALT, "halt_hold");
    cyc(1'b1, 1'b0, W_HALT, "halt_clr");
    cyc(1'b0, 1'b0, W_RST, "halt_rst");

    // illegal opcode 11111: sticky until clear
    fetch(32'hF800_0000, 0);
    cyc(1'b0, 1'b0, ew(NONE, 5'd0, 4'd3), "ill_t3");
    repeat (4) cyc(1'b0, 1'b1, W_ILL, "ill_hold");
    cyc(1'b1, 1'b0, W_ILL, "ill_clr");
    cyc(1'b0, 1'b0, W_RST, "ill_rst");

    // st aborted by clear while waiting in T7
    fetch(32'h1000_0000, 0);
    cyc(1'b0, 1'b0, ew(GRB | BAO | YI, 5'd0, 4'd3), "sta_t3");
    cyc(1'b0, 1'b0, ew(CO | ZI, 5'd3, 4'd4), "sta_t4");
    cyc(1'b0, 1'b0, ew(ZLO | MARI, 5'd0, 4'd5), "sta_t5");
    cyc(1'b0, 1'b0, ew(GRA | RO | MDRI, 5'd0, 4'd6), "sta_t6");
    cyc(1'b0, 1'b0, ew(MDRO | WR, 5'd0, 4'd7), "sta_t7_wait");
    cyc(1'b1, 1'b0, ew(MDRO | WR, 5'd0, 4'd7), "sta_t7_clr");
    cyc(1'b0, 1'b0, W_RST, "sta_abort_rst");
    cyc(1'b0, 1'b0, ew(PCO | MARI | INC, 5'd0, 4'd0), "sta_restart_t0");

    repeat (2) @(posedge clock);
    #1;
    if (Write !== 1'b0 || illegal !== 1'b0)
      $display("FAIL post_abort: got Write=%b illegal=%b required 0/0", Write, illegal);
    if (sb.size() != 0)
      $display("FAIL scoreboard: got %0d pending required 0", sb.size());
    if (n_checks < 12)
      $display("FAIL check_count: got %0d required at least 12", n_checks);
    if (n_pass != n_checks)
      $display("FAIL summary: got %0d passes required %0d", n_pass, n_checks);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
